load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: turns the single-cycle datapath's memread/memwrite, address and write data into a req/ack bus transaction to a multi-cycle data memory.
- Stalls the processor until the transaction completes, then returns read data.
- Supports byte, halfword and word accesses, big-endian lanes, alignment checks and an ack timeout.
- Sits between the ALU result / register read_data2 and the memtoreg mux.

Parameters:
TIMEOUT, 255, REQ cycles without mem_ack before abort (1..255; 8-bit counter)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high
memread  input  1  load requested by control
memwrite  input  1  store requested by control
size  input  2  LSU_BYTE=00, LSU_HALF=01, LSU_WORD=10 (11 = fault)
sign_ext  input  1  sign-extend byte/half loads (lb/lh) when 1, zero-extend when 0
address  input  32  byte address from ALU
write_data  input  32  store data, right-justified
stall  output  1  hold PC/pipeline while 1
read_data  output  32  load result, registered, valid in DONE cycle and held until next load
fault  output  1  one-cycle pulse: misaligned, illegal size, read+write both high, or timeout
mem_req  output  1  bus request, registered
mem_we  output  1  1=write
mem_addr  output  32  word-aligned address ({address[31:2],2'b00})
mem_wdata  output  32  lane-replicated store data
mem_be  output  4  byte enables, bit3 = bits 31:24
mem_ack  input  1  memory completion, sampled on posedge
mem_rdata  input  32  read data, valid with mem_ack

Behaviour:
- Reset (synchronous): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, read_data=0, fault=0, counter=0. Reset in REQ drops mem_req next cycle; any later ack is ignored.
- stall is combinational: 1 in IDLE when a legal request is present; 1 in REQ; 0 in DONE and otherwise.
- FSM IDLE:
  - Legal request (exactly one of memread/memwrite, size!=11, aligned) -> latch addr/we/be/wdata/size/sign_ext; mem_req=1 next cycle; go REQ.
  - Illegal request -> fault=1 for next cycle, no bus activity, stay IDLE, read_data unchanged.
  - mem_ack in IDLE is ignored.
- FSM REQ:
  - mem_req and all bus outputs held stable.
  - mem_ack=1 at posedge -> mem_req=0, latch aligned/extended mem_rdata into read_data (loads only), go DONE.
  - Counter reaching TIMEOUT without ack -> mem_req=0, fault=1, read_data=0 (loads), go DONE.
- FSM DONE: single cycle with stall=0, so the processor advances at its end. New requests are not accepted. Unconditionally go IDLE.
- Minimum latency with an immediate ack: request seen in cycle 0, mem_req in cycle 1, ack sampled at end of cycle 1, DONE in cycle 2. Stall therefore covers 2 cycles.
- Alignment: half requires address[0]=0; word requires address[1:0]=00.
- Byte enables (big-endian):
  - byte off0..3 -> 1000/0100/0010/0001
  - half off0 -> 1100, off2 -> 0011
  - word -> 1111
- Write lanes: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
- Read extract: selected lane right-justified, upper bits sign- or zero-extended per sign_ext; word passes through.

Decomposition:
- mips.h gains: LSU_BYTE/LSU_HALF/LSU_WORD size codes, LSU_IDLE/LSU_REQ/LSU_DONE state codes, default TIMEOUT.
- One combinational sub-module lsu_lane_align: (size, addr[1:0], sign_ext, write_data, mem_rdata) -> (mem_be, mem_wdata, extracted read value, misaligned).

Test Plan:
- Word store addr=0x10010004, wd=0xDEADBEEF, ack 1 cycle after req -> mem_addr=0x10010004, be=1111, wdata=0xDEADBEEF, mem_we=1; stall high 2 cycles, then DONE, no fault.
- lb addr=0x10010003, sign_ext=1, rdata=0x112233F0, ack after 3 cycles -> be=0001, read_data=0xFFFFFFF0; lbu same -> 0x000000F0; stall high 4 cycles.
- sh addr=0x10010002, wd=0x0000ABCD -> be=0011, wdata=0xABCDABCD; lh from off0 with rdata=0x8001xxxx -> read_data=0xFFFF8001.
- Word load addr=0x10010002 -> fault pulse 1 cycle, mem_req never rises, stall 0, read_data unchanged; repeat with memread=memwrite=1 and with size=11 -> same response.
- Load with no ack, TIMEOUT=4 -> mem_req held 4 cycles, then drops; fault=1, read_data=0, DONE then IDLE; an ack arriving later is ignored.
- reset asserted in REQ -> next cycle mem_req=0, state IDLE, stall=0; a stray ack in the following cycle leaves read_data=0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared size codes, FSM states and defaults for the load/store unit.
package load_store_unit_pkg;

  localparam logic [1:0] LSU_BYTE = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_WORD = 2'b10;

  localparam int LSU_DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_DONE = 2'b10
  } lsu_state_e;

  function automatic logic [31:0] lsu_extend_byte(input logic [7:0] b, input logic sext);
    return sext ? {{24{b[7]}}, b} : {24'b0, b};
  endfunction

  function automatic logic [31:0] lsu_extend_half(input logic [15:0] h, input logic sext);
    return sext ? {{16{h[15]}}, h} : {16'b0, h};
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Big-endian lane steering: byte enables and replicated store data going out,
// right-justified and extended load data coming back, plus the alignment check.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] write_data,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic [31:0] read_value,
  output logic        misaligned
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Offset 0 is the most significant lane (big-endian).
  always_comb begin
    lane_byte = 8'h00;
    case (offset)
      2'd0:    lane_byte = mem_rdata[31:24];
      2'd1:    lane_byte = mem_rdata[23:16];
      2'd2:    lane_byte = mem_rdata[15:8];
      default: lane_byte = mem_rdata[7:0];
    endcase
    lane_half = offset[1] ? mem_rdata[15:0] : mem_rdata[31:16];
  end

  always_comb begin
    mem_be     = 4'b0000;
    mem_wdata  = 32'h0;
    read_value = 32'h0;
    misaligned = 1'b0;
    case (size)
      LSU_BYTE: begin
        mem_be     = 4'b1000 >> offset;
        mem_wdata  = {4{write_data[7:0]}};
        read_value = lsu_extend_byte(lane_byte, sign_ext);
      end
      LSU_HALF: begin
        mem_be     = offset[1] ? 4'b0011 : 4'b1100;
        mem_wdata  = {2{write_data[15:0]}};
        read_value = lsu_extend_half(lane_half, sign_ext);
        misaligned = offset[0];
      end
      LSU_WORD: begin
        mem_be     = 4'b1111;
        mem_wdata  = write_data;
        read_value = mem_rdata;
        misaligned = |offset;
      end
      default: begin
        mem_be     = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: turns memread/memwrite into a req/ack bus transaction,
// stalling the datapath until the access completes, faults, or times out.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = LSU_DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        stall,
  output logic [31:0] read_data,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  lsu_state_e  state, next_state;
  logic [7:0]  count, next_count;
  logic [1:0]  lat_size, next_lat_size;
  logic [1:0]  lat_off, next_lat_off;
  logic        lat_sext, next_lat_sext;
  logic        next_req, next_we, next_fault;
  logic [31:0] next_addr, next_wdata, next_read;
  logic [3:0]  next_be;

  logic [1:0]  al_size, al_off;
  logic        al_sext, al_misaligned;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_read;
  logic        req_any, req_legal;

  // In IDLE the aligner checks the live request; afterwards it decodes the
  // latched access so the returning data is extracted with the right lane.
  assign al_size = (state == LSU_IDLE) ? size : lat_size;
  assign al_off  = (state == LSU_IDLE) ? address[1:0] : lat_off;
  assign al_sext = (state == LSU_IDLE) ? sign_ext : lat_sext;

  lsu_lane_align u_align (
    .size       (al_size),
    .offset     (al_off),
    .sign_ext   (al_sext),
    .write_data (write_data),
    .mem_rdata  (mem_rdata),
    .mem_be     (al_be),
    .mem_wdata  (al_wdata),
    .read_value (al_read),
    .misaligned (al_misaligned)
  );

  assign req_any   = memread | memwrite;
  assign req_legal = (memread ^ memwrite) && (size != 2'b11) && !al_misaligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LSU_IDLE;
      count     <= 8'd0;
      lat_size  <= LSU_BYTE;
      lat_off   <= 2'b00;
      lat_sext  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'b0000;
      read_data <= 32'h0;
      fault     <= 1'b0;
    end else begin
      state     <= next_state;
      count     <= next_count;
      lat_size  <= next_lat_size;
      lat_off   <= next_lat_off;
      lat_sext  <= next_lat_sext;
      mem_req   <= next_req;
      mem_we    <= next_we;
      mem_addr  <= next_addr;
      mem_wdata <= next_wdata;
      mem_be    <= next_be;
      read_data <= next_read;
      fault     <= next_fault;
    end
  end

  always_comb begin
    next_state    = state;
    next_count    = count;
    next_lat_size = lat_size;
    next_lat_off  = lat_off;
    next_lat_sext = lat_sext;
    next_req      = mem_req;
    next_we       = mem_we;
    next_addr     = mem_addr;
    next_wdata    = mem_wdata;
    next_be       = mem_be;
    next_read     = read_data;
    next_fault    = 1'b0;
    stall         = 1'b0;
    case (state)
      LSU_IDLE: begin
        if (req_any && req_legal) begin
          stall         = 1'b1;
          next_state    = LSU_REQ;
          next_count    = 8'd0;
          next_lat_size = size;
          next_lat_off  = address[1:0];
          next_lat_sext = sign_ext;
          next_req      = 1'b1;
          next_we       = memwrite;
          next_addr     = {address[31:2], 2'b00};
          next_wdata    = al_wdata;
          next_be       = al_be;
        end else if (req_any) begin
          next_fault = 1'b1;
        end
      end
      LSU_REQ: begin
        stall = 1'b1;
        // An ack in the final counted cycle still wins over the timeout.
        if (mem_ack) begin
          next_req   = 1'b0;
          next_state = LSU_DONE;
          if (!mem_we) next_read = al_read;
        end else if (count == LAST_COUNT) begin
          next_req   = 1'b0;
          next_fault = 1'b1;
          next_state = LSU_DONE;
          if (!mem_we) next_read = 32'h0;
        end else begin
          next_count = count + 8'd1;
        end
      end
      LSU_DONE: begin
        next_state = LSU_IDLE;
      end
      default: begin
        next_state = LSU_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite, sign_ext, mem_ack;
  logic [1:0]  size;
  logic [31:0] address, write_data, mem_rdata;
  logic        stall, fault, mem_req, mem_we;
  logic [31:0] read_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int check_count = 0;
  int pass_count  = 0;

  int          obs_stall_cycles, obs_req_cycles;
  logic [31:0] obs_addr, obs_wdata, obs_read;
  logic [3:0]  obs_be;
  logic        obs_we, obs_fault, obs_req_end, obs_fault_after, obs_req_after;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .memread    (memread),
    .memwrite   (memwrite),
    .size       (size),
    .sign_ext   (sign_ext),
    .address    (address),
    .write_data (write_data),
    .stall      (stall),
    .read_data  (read_data),
    .fault      (fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  // Issue one request at a negedge; ack after ack_after REQ cycles (0 = never).
  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] sz, input logic sext,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input int ack_after, input logic [31:0] rdata);
    int k;
    @(negedge clk);
    memread = rd; memwrite = wr; size = sz; sign_ext = sext;
    address = addr; write_data = wd; mem_ack = 1'b0; mem_rdata = 32'h0;
    obs_stall_cycles = 0; obs_req_cycles = 0;
    obs_addr = 32'hx; obs_wdata = 32'hx; obs_be = 4'hx; obs_we = 1'bx;
    #1;
    k = 0;
    while (stall && k < 40) begin
      obs_stall_cycles++;
      @(negedge clk);
      memread = 1'b0; memwrite = 1'b0; mem_ack = 1'b0;
      #1;
      if (mem_req) begin
        obs_req_cycles++;
        obs_addr = mem_addr; obs_wdata = mem_wdata; obs_be = mem_be; obs_we = mem_we;
        if (obs_req_cycles == ack_after) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end
      end
      k++;
    end
    if (k >= 40) checkOutput("stall_bound", 32'(k), 32'd0);
    if (obs_stall_cycles == 0) begin
      @(negedge clk);
      memread = 1'b0; memwrite = 1'b0;
      #1;
    end
    obs_fault = fault; obs_read = read_data; obs_req_end = mem_req;
    @(negedge clk);
    #1;
    obs_fault_after = fault; obs_req_after = mem_req;
  endtask

  initial begin
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; size = 2'b00; sign_ext = 1'b0;
    address = 32'h0; write_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_be", 32'(mem_be), 32'd0);
    checkOutput("rst_addr", mem_addr, 32'h0);
    checkOutput("rst_read", read_data, 32'h0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    reset = 1'b0;

    // sw
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 1, 32'h0);
    checkOutput("sw_stall", 32'(obs_stall_cycles), 32'd2);
    checkOutput("sw_req_cycles", 32'(obs_req_cycles), 32'd1);
    checkOutput("sw_addr", obs_addr, 32'h1001_0004);
    checkOutput("sw_be", 32'(obs_be), 32'hF);
    checkOutput("sw_wdata", obs_wdata, 32'hDEAD_BEEF);
    checkOutput("sw_we", 32'(obs_we), 32'd1);
    checkOutput("sw_fault", 32'(obs_fault), 32'd0);
    checkOutput("sw_req_done", 32'(obs_req_end), 32'd0);

    // lb / lbu at offset 3, ack in third REQ cycle
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h1001_0003, 32'h0, 3, 32'h1122_33F0);
    checkOutput("lb_stall", 32'(obs_stall_cycles), 32'd4);
    checkOutput("lb_be", 32'(obs_be), 32'h1);
    checkOutput("lb_addr", obs_addr, 32'h1001_0000);
    checkOutput("lb_we", 32'(obs_we), 32'd0);
    checkOutput("lb_read", obs_read, 32'hFFFF_FFF0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h1001_0003, 32'h0, 3, 32'h1122_33F0);
    checkOutput("lbu_stall", 32'(obs_stall_cycles), 32'd4);
    checkOutput("lbu_read", obs_read, 32'h0000_00F0);

    // sh at offset 2; store leaves read_data alone
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h1001_0002, 32'h0000_ABCD, 1, 32'h0);
    checkOutput("sh_be", 32'(obs_be), 32'h3);
    checkOutput("sh_wdata", obs_wdata, 32'hABCD_ABCD);
    checkOutput("sh_read_kept", obs_read, 32'h0000_00F0);

    // lh offset 0, lhu offset 2, lb offset 1, lw
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 32'h1001_0000, 32'h0, 2, 32'h8001_1234);
    checkOutput("lh_be", 32'(obs_be), 32'hC);
    checkOutput("lh_read", obs_read, 32'hFFFF_8001);
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h1001_0006, 32'h0, 1, 32'h1234_F00D);
    checkOutput("lhu_read", obs_read, 32'h0000_F00D);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h1001_0001, 32'h0, 1, 32'h1122_3344);
    checkOutput("lb1_be", 32'(obs_be), 32'h4);
    checkOutput("lb1_read", obs_read, 32'h0000_0022);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b1, 32'h1001_0008, 32'h0, 1, 32'h89AB_CDEF);
    checkOutput("lw_read", obs_read, 32'h89AB_CDEF);

    // illegal requests: misaligned word, read+write, size 11, misaligned half
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0002, 32'h0, 1, 32'h5555_5555);
    checkOutput("mis_w_stall", 32'(obs_stall_cycles), 32'd0);
    checkOutput("mis_w_fault", 32'(obs_fault), 32'd1);
    checkOutput("mis_w_req", 32'(obs_req_end), 32'd0);
    checkOutput("mis_w_read", obs_read, 32'h89AB_CDEF);
    checkOutput("mis_w_pulse", 32'(obs_fault_after), 32'd0);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h1001_0000, 32'h0, 1, 32'h5555_5555);
    checkOutput("rw_stall", 32'(obs_stall_cycles), 32'd0);
    checkOutput("rw_fault", 32'(obs_fault), 32'd1);
    checkOutput("rw_req", 32'(obs_req_end), 32'd0);
    checkOutput("rw_pulse", 32'(obs_fault_after), 32'd0);
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 32'h1001_0000, 32'h0, 1, 32'h5555_5555);
    checkOutput("sz11_stall", 32'(obs_stall_cycles), 32'd0);
    checkOutput("sz11_fault", 32'(obs_fault), 32'd1);
    checkOutput("sz11_read", obs_read, 32'h89AB_CDEF);
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h1001_0001, 32'h0, 1, 32'h0);
    checkOutput("mis_h_fault", 32'(obs_fault), 32'd1);
    checkOutput("mis_h_req", 32'(obs_req_after), 32'd0);

    // timeout with TIMEOUT=4
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_000C, 32'h0, 0, 32'h0);
    checkOutput("to_req_cycles", 32'(obs_req_cycles), 32'd4);
    checkOutput("to_stall", 32'(obs_stall_cycles), 32'd5);
    checkOutput("to_fault", 32'(obs_fault), 32'd1);
    checkOutput("to_read", obs_read, 32'h0);
    checkOutput("to_req_done", 32'(obs_req_end), 32'd0);
    checkOutput("to_pulse", 32'(obs_fault_after), 32'd0);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checkOutput("late_ack_read", read_data, 32'h0);
    checkOutput("late_ack_stall", 32'(stall), 32'd0);
    checkOutput("late_ack_req", 32'(mem_req), 32'd0);

    // reset while in REQ
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0010, 32'h0, 1, 32'h0BAD_F00D);
    checkOutput("pre_rst_read", obs_read, 32'h0BAD_F00D);
    @(negedge clk);
    memread = 1'b1; size = 2'b10; address = 32'h1001_0010; sign_ext = 1'b0;
    #1;
    checkOutput("rreq_stall", 32'(stall), 32'd1);
    @(negedge clk);
    memread = 1'b0;
    #1;
    checkOutput("rreq_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rreq_req_drop", 32'(mem_req), 32'd0);
    checkOutput("rreq_stall_drop", 32'(stall), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checkOutput("rreq_stray_read", read_data, 32'h0);
    checkOutput("rreq_stray_stall", 32'(stall), 32'd0);
    checkOutput("rreq_stray_req", 32'(mem_req), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
